morse_sequencer: RTL and testbench

Controller for the Morse audio path: it takes a 10-bit symbol pattern from the CPU's I/O port, times dots, dashes and gaps from a prescaled time unit, and drives the tone line plus per-symbol dot/dash indicators. It sits between the audio pattern register written by the processor and the speaker/LED outputs, replacing free-running serialisation with a start/busy/done handshake the CPU can poll.

---
 rtl/morse_sequencer_pkg.sv | 24 ++
 rtl/morse_sequencer_if.sv | 25 ++
 rtl/morse_sequencer_unit_timer.sv | 35 +++
 rtl/morse_sequencer.sv | 126 ++++++++++++
 tb/tb_morse_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/morse_sequencer_pkg.sv
// Shared definitions for the Morse sequencer: FSM state encoding, 2-bit
// symbol codes, symbol/gap lengths in time units and symbols per pattern.
package morse_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_TONE  = 3'd2,
    ST_GAP   = 3'd3,
    ST_LGAP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_RSV  = 2'b11;

  localparam logic [1:0] DOT_UNITS  = 2'd1;
  localparam logic [1:0] DASH_UNITS = 2'd3;
  localparam logic [1:0] GAP_UNITS  = 2'd1;
  localparam logic [1:0] LGAP_UNITS = 2'd3;

  localparam logic [2:0] MAX_SYMS = 3'd5;
endpackage

// File: rtl/morse_sequencer_if.sv
// CPU-side handshake and audio/indicator outputs of the Morse sequencer.
//   start/abort/pattern : CPU -> sequencer
//   busy/done           : playback status
//   tone/sym_dot/sym_dash/sym_count : speaker and LED drive
interface morse_sequencer_if;
  logic       start;
  logic       abort;
  logic [9:0] pattern;
  logic       busy;
  logic       done;
  logic       tone;
  logic       sym_dot;
  logic       sym_dash;
  logic [2:0] sym_count;

  modport master (
    output start, abort, pattern,
    input  busy, done, tone, sym_dot, sym_dash, sym_count
  );

  modport slave (
    input  start, abort, pattern,
    output busy, done, tone, sym_dot, sym_dash, sym_count
  );
endinterface

// File: rtl/morse_sequencer_unit_timer.sv
// Time-unit counter for one FSM state.
//   clk, reset : clock, async active-high reset
//   clear_i    : reload count to 0 (asserted on state entry / while idle)
//   units_i    : length of the current state in Morse units (0 = untimed)
//   expire_o   : high on the last cycle, count == units_i*TICK_DIV-1
module unit_timer #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic [1:0] units_i,
  output logic       expire_o
);
  localparam int CW = $clog2(3 * TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   limit;

  // units_i == 0 wraps the limit to all-ones, so untimed states never expire
  assign limit    = 32'(units_i) * 32'(TICK_DIV) - 32'd1;
  assign expire_o = (32'(cnt_q) == limit);

  // saturate at the limit rather than wrap; the FSM leaves the state anyway
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)        cnt_d = '0;
    else if (!expire_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/morse_sequencer.sv
// Morse playback controller: latches a 5-symbol pattern on start, plays
// dots/dashes with inter-symbol and letter gaps, then pulses done.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of morse_sequencer_if (start/abort/pattern in,
//                busy/done/tone/sym_dot/sym_dash/sym_count out)
// All outputs are registered from the next-state decode.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  morse_sequencer_if.slave   bus
);
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_TONE  = ST_TONE;
  localparam logic [2:0] S_GAP   = ST_GAP;
  localparam logic [2:0] S_LGAP  = ST_LGAP;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0] state_q, state_d;
  logic [9:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] len_q, len_d;
  logic       is_dash_q, is_dash_d;
  logic       busy_q, done_q, tone_q, dot_q, dash_q;
  logic       tone_d;
  logic [2:0] cnt_inc;
  logic [1:0] units;
  logic       clear, expire;

  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    is_dash_d = is_dash_q;
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;  // sym_count deliberately held
    end else begin
      case (state_q)
        S_IDLE: if (bus.start && !bus.abort) begin
          shift_d = bus.pattern;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
        S_FETCH: case (shift_q[9:8])
          SYM_DOT:  begin len_d = DOT_UNITS;  is_dash_d = 1'b0; state_d = S_TONE; end
          SYM_DASH: begin len_d = DASH_UNITS; is_dash_d = 1'b1; state_d = S_TONE; end
          SYM_END, SYM_RSV: state_d = S_LGAP;
          default:  state_d = S_LGAP;
        endcase
        S_TONE: if (expire) state_d = S_GAP;
        S_GAP: if (expire) begin
          shift_d = {shift_q[7:0], 2'b00};
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == MAX_SYMS) ? S_LGAP : S_FETCH;
        end
        S_LGAP: if (expire) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    units = 2'd0;
    case (state_q)
      S_TONE:  units = len_q;
      S_GAP:   units = GAP_UNITS;
      S_LGAP:  units = LGAP_UNITS;
      default: units = 2'd0;
    endcase
  end

  // restart the unit count on every state change and keep it parked in IDLE
  assign clear = (state_d != state_q) || (state_q == S_IDLE);

  unit_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear),
    .units_i  (units),
    .expire_o (expire)
  );

  assign tone_d = (state_d == S_TONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      is_dash_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tone_q    <= 1'b0;
      dot_q     <= 1'b0;
      dash_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      is_dash_q <= is_dash_d;
      busy_q    <= (state_d == S_FETCH) || (state_d == S_TONE) ||
                   (state_d == S_GAP)   || (state_d == S_LGAP);
      done_q    <= (state_d == S_DONE);
      tone_q    <= tone_d;
      dot_q     <= tone_d && !is_dash_d;
      dash_q    <= tone_d && is_dash_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tone      = tone_q;
  assign bus.sym_dot   = dot_q;
  assign bus.sym_dash  = dash_q;
  assign bus.sym_count = cnt_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer at TICK_DIV=4. Stimulus pushes the
// hand-computed waveform events of each run; a negedge monitor turns the
// DUT outputs into events (tone pulses, done, abort) and compares them.
module tb_morse_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  morse_sequencer_if bus();
  morse_sequencer #(.TICK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  // TONE : len = high cycles, typ = {dash,dot} (3 = mixed), low = busy&!tone cycles before rise
  // DONE/ABORT : len = busy cycles, typ = sym_count (+8 if an indicator lit without tone), low = trailing low cycles
  localparam int K_TONE = 0, K_DONE = 1, K_ABORT = 2, K_STRAY = 3;
  typedef struct { int kind; int len; int typ; int low; } ev_t;
  ev_t exp_q[$];
  int vectors = 0, miscompares = 0;

  function automatic void push(input int k, input int l, input int t, input int lo);
    ev_t e;
    e.kind = k; e.len = l; e.typ = t; e.low = lo;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic emit(input int k, input int l, input int t, input int lo);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d len=%0d typ=%0d low=%0d, expected none",
               k, l, t, lo);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.len != l || e.typ != t || e.low != lo) begin
        miscompares++;
        $display("FAIL event: got kind=%0d len=%0d typ=%0d low=%0d, expected kind=%0d len=%0d typ=%0d low=%0d",
                 k, l, t, lo, e.kind, e.len, e.typ, e.low);
      end
    end
  endtask

  // monitor
  initial begin
    int tlen, ttyp, low, low_pre, blen, bad;
    logic p_tone, p_busy;
    tlen = 0; ttyp = 0; low = 0; low_pre = 0; blen = 0; bad = 0;
    p_tone = 1'b0; p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tlen = 0; ttyp = 0; low = 0; low_pre = 0; blen = 0; bad = 0;
        p_tone = 1'b0; p_busy = 1'b0;
      end else begin
        if (bus.tone) begin
          if (!p_tone) begin
            low_pre = low; low = 0; tlen = 0;
            ttyp = {30'd0, bus.sym_dash, bus.sym_dot};
          end
          tlen++;
          if ({30'd0, bus.sym_dash, bus.sym_dot} != ttyp) ttyp = 3;
        end else begin
          if (p_tone) emit(K_TONE, tlen, ttyp, low_pre);
          if (bus.sym_dot || bus.sym_dash) bad = 8;
          if (bus.busy) low++;
        end
        if (bus.busy) blen++;
        if (p_busy && !bus.busy) begin
          emit(bus.done ? K_DONE : K_ABORT, blen, int'(bus.sym_count) + bad, low);
          blen = 0; low = 0; bad = 0;
        end else if (bus.done) begin
          emit(K_STRAY, blen, int'(bus.sym_count), low);
        end
        p_tone = bus.tone;
        p_busy = bus.busy;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [9:0] pat, input bit disturb);
    bit seen;
    bus.pattern = pat;
    bus.start   = 1'b1;
    cyc();
    bus.start = disturb;
    if (disturb) bus.pattern = 10'($urandom);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      cyc();
      if (disturb) begin
        bus.start   = 1'(n & 1);
        bus.pattern = 10'($urandom);
      end
      if (bus.done) begin
        seen = 1'b1;
        if (disturb) bus.start = 1'b1;  // offered while in DONE, must be ignored
      end
    end
    check("done_within_budget", int'(seen), 1);
    cyc();
    bus.start = 1'b0;
    repeat (20) cyc();
  endtask

  initial begin
    int rises;
    logic prev;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({bus.busy, bus.done, bus.tone, bus.sym_dot, bus.sym_dash, bus.sym_count}), 0);
    reset = 1'b0;
    repeat (2) cyc();

    // single dot
    push(K_TONE, 4, 1, 1); push(K_DONE, 22, 1, 17);
    run(10'b0100000000, 1'b0);

    // five dashes, letter gap after fifth symbol
    push(K_TONE, 12, 2, 1);
    for (int i = 0; i < 4; i++) push(K_TONE, 12, 2, 5);
    push(K_DONE, 97, 5, 16);
    run(10'b1010101010, 1'b0);

    // empty pattern
    push(K_DONE, 13, 0, 13);
    run(10'b0000000000, 1'b0);

    // dot, dash, reserved code ends the letter
    push(K_TONE, 4, 1, 1); push(K_TONE, 12, 2, 5); push(K_DONE, 39, 2, 17);
    run(10'b0110110000, 1'b0);

    // same with start re-pulsed and pattern scrambled while busy
    push(K_TONE, 4, 1, 1); push(K_TONE, 12, 2, 5); push(K_DONE, 39, 2, 17);
    run(10'b0110110000, 1'b1);

    // abort in the third cycle of the second tone
    push(K_TONE, 4, 1, 1); push(K_TONE, 3, 2, 5); push(K_ABORT, 13, 1, 0);
    bus.pattern = 10'b0110110000;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 100 && rises < 2; n++) begin
      cyc();
      if (bus.tone && !prev) rises++;
      prev = bus.tone;
    end
    check("abort_second_tone_reached", rises, 2);
    cyc(); cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_outputs_low", int'({bus.busy, bus.done, bus.tone, bus.sym_dot, bus.sym_dash}), 0);
    check("abort_sym_count_held", int'(bus.sym_count), 1);
    repeat (10) cyc();

    // abort beats start in IDLE
    bus.pattern = 10'b0100000000;
    bus.start = 1'b1; bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0; bus.abort = 1'b0;
    cyc();
    check("abort_priority_busy", int'(bus.busy), 0);
    repeat (5) cyc();

    // fresh start after abort plays normally
    push(K_TONE, 4, 1, 1); push(K_DONE, 22, 1, 17);
    run(10'b0100000000, 1'b0);

    // async reset during a dash
    bus.pattern = 10'b1000000000;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    rises = 0;
    for (int n = 0; n < 50 && rises == 0; n++) begin
      cyc();
      if (bus.tone) rises = 1;
    end
    check("reset_dash_reached", rises, 1);
    cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", int'({bus.busy, bus.done, bus.tone, bus.sym_dot, bus.sym_dash, bus.sym_count}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) cyc();
    check("idle_after_reset", int'({bus.busy, bus.tone}), 0);

    push(K_TONE, 4, 1, 1); push(K_DONE, 22, 1, 17);
    run(10'b0100000000, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
